// File: rtl/tlul_arb_2to1_pkg.sv
// rtl/tlul_arb_2to1_pkg.sv - host index and transaction state types for the 2:1 TL-UL arbiter
package tlul_arb_2to1_pkg;

  typedef enum logic {HOST0 = 1'b0, HOST1 = 1'b1} host_idx_e;
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} arb_state_e;

  function automatic host_idx_e other_host(host_idx_e h);
    return host_idx_e'(~h);
  endfunction

endpackage

// File: rtl/tlul_pkg.sv
// rtl/tlul_pkg.sv - TL-UL channel A/D request and response structs
package tlul_pkg;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic [15:0] a_user;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic [15:0] d_user;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

endpackage

// File: rtl/tlul_arb_2to1_if.sv
// rtl/tlul_arb_2to1_if.sv - bundle of the two host ports and the shared device port
interface tlul_arb_2to1_if;

  tlul_pkg::tl_h2d_t h2d_h0_i;
  tlul_pkg::tl_d2h_t d2h_h0_o;
  tlul_pkg::tl_h2d_t h2d_h1_i;
  tlul_pkg::tl_d2h_t d2h_h1_o;
  tlul_pkg::tl_h2d_t h2d_dev_o;
  tlul_pkg::tl_d2h_t d2h_dev_i;

  // slave: the arbiter itself; master: the hosts and device around it
  modport slave (
    input  h2d_h0_i, h2d_h1_i, d2h_dev_i,
    output d2h_h0_o, d2h_h1_o, h2d_dev_o
  );

  modport master (
    output h2d_h0_i, h2d_h1_i, d2h_dev_i,
    input  d2h_h0_o, d2h_h1_o, h2d_dev_o
  );

endinterface

// File: rtl/tlul_arb_2to1_rr_arb_2.sv
// rtl/tlul_arb_2to1_rr_arb_2.sv - two-way round-robin arbiter; priority flips only on advance
module tlul_arb_2to1_rr_arb_2
  import tlul_arb_2to1_pkg::*;
#(
  parameter logic PRIO_INIT = 1'b0
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic [1:0] req,
  input  logic      advance,
  output host_idx_e gnt_idx
);

  host_idx_e prio_q;

  // with no or both requests the priority holder wins, so a stalled lone
  // requester keeps its grant until it is accepted
  always_comb begin
    gnt_idx = prio_q;
    unique case (req)
      2'b01:   gnt_idx = HOST0;
      2'b10:   gnt_idx = HOST1;
      default: gnt_idx = prio_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prio_q <= host_idx_e'(PRIO_INIT);
    end else if (advance) begin
      prio_q <= other_host(gnt_idx);
    end
  end

endmodule

// File: rtl/tlul_arb_2to1.sv
// rtl/tlul_arb_2to1.sv - 2-host to 1-device TL-UL arbiter, one transaction outstanding in total
module tlul_arb_2to1
  import tlul_pkg::*;
  import tlul_arb_2to1_pkg::*;
#(
  parameter logic PRIO_INIT = 1'b0
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  tlul_arb_2to1_if.slave  bus
);

  arb_state_e state_q;
  host_idx_e  owner_q;
  host_idx_e  gnt;
  tl_h2d_t    req_sel;
  tl_h2d_t    req_own;
  tl_h2d_t    h2d_dev;
  tl_d2h_t    d2h_h0;
  tl_d2h_t    d2h_h1;
  tl_d2h_t    rsp_fwd;
  logic       a_fire;
  logic       d_fire;

  tlul_arb_2to1_rr_arb_2 #(
    .PRIO_INIT (PRIO_INIT)
  ) u_rr_arb (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .req     ({bus.h2d_h1_i.a_valid, bus.h2d_h0_i.a_valid}),
    .advance (a_fire),
    .gnt_idx (gnt)
  );

  assign req_sel = (gnt == HOST1)     ? bus.h2d_h1_i : bus.h2d_h0_i;
  assign req_own = (owner_q == HOST1) ? bus.h2d_h1_i : bus.h2d_h0_i;

  assign a_fire = (state_q == IDLE) && req_sel.a_valid && bus.d2h_dev_i.a_ready;
  assign d_fire = (state_q == BUSY) && bus.d2h_dev_i.d_valid && req_own.d_ready;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      owner_q <= HOST0;
    end else if (a_fire) begin
      state_q <= BUSY;
      owner_q <= gnt;
    end else if (d_fire) begin
      state_q <= IDLE;
    end
  end

  always_comb begin
    h2d_dev         = '0;
    d2h_h0          = '0;
    d2h_h1          = '0;
    rsp_fwd         = bus.d2h_dev_i;
    rsp_fwd.a_ready = 1'b0;
    unique case (state_q)
      IDLE: begin
        // device responses here are protocol violations and are dropped
        if (req_sel.a_valid) begin
          h2d_dev         = req_sel;
          h2d_dev.d_ready = 1'b0;
        end
        if (gnt == HOST0) begin
          d2h_h0.a_ready = bus.d2h_dev_i.a_ready;
        end else begin
          d2h_h1.a_ready = bus.d2h_dev_i.a_ready;
        end
      end
      BUSY: begin
        h2d_dev.d_ready = req_own.d_ready;
        if (owner_q == HOST0) begin
          d2h_h0 = rsp_fwd;
        end else begin
          d2h_h1 = rsp_fwd;
        end
      end
      default: ;
    endcase
  end

  assign bus.h2d_dev_o = h2d_dev;
  assign bus.d2h_h0_o  = d2h_h0;
  assign bus.d2h_h1_o  = d2h_h1;

endmodule

// File: tb/tb_tlul_arb_2to1.sv
// tb/tb_tlul_arb_2to1.sv - directed and random checks of tlul_arb_2to1 against a transaction-level model
module tb_tlul_arb_2to1;
  import tlul_pkg::*;

  localparam int PRIO = 0;

  logic clk_i;
  logic rst_ni;

  tlul_arb_2to1_if bus ();

  tlul_arb_2to1 #(
    .PRIO_INIT (1'(PRIO))
  ) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  // stimulus and model state
  tl_h2d_t rq [2];
  tl_d2h_t rd;
  bit      m_busy;
  int      m_owner;
  int      m_prio;
  int      m_gnt;
  bit      m_afire;
  bit      m_dfire;
  tl_h2d_t obs_dev;
  tl_d2h_t obs_rsp [2];
  int      gnt_log [$];
  logic [31:0] addr_log [$];

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic tl_h2d_t idle_h(input bit dr);
    tl_h2d_t t;
    t = '0;
    t.d_ready = dr;
    return t;
  endfunction

  function automatic tl_h2d_t mk_get(input logic [31:0] addr, input logic [7:0] src, input bit dr);
    tl_h2d_t t;
    t           = '0;
    t.a_valid   = 1'b1;
    t.a_opcode  = 3'h4;
    t.a_size    = 2'h2;
    t.a_source  = src;
    t.a_address = addr;
    t.a_mask    = 4'hF;
    t.a_data    = addr ^ 32'h5A5A_0000;
    t.a_user    = {8'hA5, src};
    t.d_ready   = dr;
    return t;
  endfunction

  function automatic tl_d2h_t mk_rsp(input bit dv, input logic [31:0] data, input bit ar, input logic [7:0] src);
    tl_d2h_t t;
    t          = '0;
    t.d_valid  = dv;
    t.d_opcode = 3'h1;
    t.d_size   = 2'h2;
    t.d_source = src;
    t.d_data   = data;
    t.d_user   = {8'h3C, src};
    t.a_ready  = ar;
    return t;
  endfunction

  // expected outputs from the arbitration rules, then compare against the DUT
  task automatic compare_now(input string tag);
    tl_h2d_t ed;
    tl_d2h_t er [2];
    int g;
    bus.h2d_h0_i = rq[0];
    bus.h2d_h1_i = rq[1];
    bus.d2h_dev_i = rd;
    #1;
    if (rq[0].a_valid && !rq[1].a_valid)      g = 0;
    else if (rq[1].a_valid && !rq[0].a_valid) g = 1;
    else                                      g = m_prio;
    ed = '0;
    er[0] = '0;
    er[1] = '0;
    m_afire = 1'b0;
    m_dfire = 1'b0;
    if (!m_busy) begin
      if (rq[g].a_valid) begin
        ed = rq[g];
        ed.d_ready = 1'b0;
      end
      er[g].a_ready = rd.a_ready;
      m_afire = rq[g].a_valid && rd.a_ready;
    end else begin
      ed.d_ready = rq[m_owner].d_ready;
      er[m_owner] = rd;
      er[m_owner].a_ready = 1'b0;
      m_dfire = rd.d_valid && rq[m_owner].d_ready;
    end
    m_gnt = g;
    obs_dev    = bus.h2d_dev_o;
    obs_rsp[0] = bus.d2h_h0_o;
    obs_rsp[1] = bus.d2h_h1_o;
    check_eq({tag, ".dev"}, 128'(obs_dev), 128'(ed));
    check_eq({tag, ".h0"}, 128'(obs_rsp[0]), 128'(er[0]));
    check_eq({tag, ".h1"}, 128'(obs_rsp[1]), 128'(er[1]));
  endtask

  task automatic step(input string tag);
    compare_now(tag);
    @(posedge clk_i);
    if (m_afire) begin
      m_busy  = 1'b1;
      m_owner = m_gnt;
      m_prio  = 1 - m_gnt;
      gnt_log.push_back(obs_rsp[1].a_ready ? 1 : 0);
      addr_log.push_back(obs_dev.a_address);
    end else if (m_dfire) begin
      m_busy = 1'b0;
    end
    @(negedge clk_i);
  endtask

  task automatic do_reset(input string tag);
    rst_ni  = 1'b0;
    m_busy  = 1'b0;
    m_owner = 0;
    m_prio  = PRIO;
    compare_now(tag);
    @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  initial begin
    int cnt [2];
    rq[0] = idle_h(1'b0);
    rq[1] = idle_h(1'b0);
    rd    = '0;
    @(negedge clk_i);
    do_reset("reset");

    // host0 Get, response two cycles later
    rq[0] = mk_get(32'h1000_0004, 8'h11, 1'b1);
    rd    = mk_rsp(1'b0, 32'h0, 1'b1, 8'h00);
    step("s1_req");
    check_eq("s1_addr", 128'(obs_dev.a_address), 128'(32'h1000_0004));
    check_eq("s1_aready", 128'(obs_rsp[0].a_ready), 128'(1'b1));
    rq[0] = idle_h(1'b1);
    step("s1_wait0");
    step("s1_wait1");
    rd = mk_rsp(1'b1, 32'hCAFE_F00D, 1'b1, 8'h11);
    step("s1_rsp");
    check_eq("s1_data", 128'(obs_rsp[0].d_data), 128'(32'hCAFE_F00D));
    check_eq("s1_h0dv", 128'(obs_rsp[0].d_valid), 128'(1'b1));
    check_eq("s1_h1dv", 128'(obs_rsp[1].d_valid), 128'(1'b0));
    rd = mk_rsp(1'b0, 32'h0, 1'b1, 8'h00);
    step("s1_idle");
    check_eq("s1_idle_ar", 128'(obs_rsp[1].a_ready), 128'(1'b1));

    // host1 stalled by the device; host0 joins later and must not steal the grant
    rq[1] = mk_get(32'h2000_0010, 8'h21, 1'b1);
    rd    = mk_rsp(1'b0, 32'h0, 1'b0, 8'h00);
    for (int i = 0; i < 5; i++) begin
      if (i >= 2) rq[0] = mk_get(32'h3000_0000, 8'h01, 1'b1);
      step("s3_stall");
      check_eq("s3_hold", 128'(obs_dev.a_address), 128'(32'h2000_0010));
    end
    rd = mk_rsp(1'b0, 32'h0, 1'b1, 8'h00);
    step("s3_fire");
    check_eq("s3_h1_ar", 128'(obs_rsp[1].a_ready), 128'(1'b1));
    check_eq("s3_src", 128'(obs_dev.a_source), 128'(8'h21));
    rq[1] = idle_h(1'b1);
    rd = mk_rsp(1'b1, 32'h0BAD_CAFE, 1'b1, 8'h21);
    step("s3_rsp");
    check_eq("s3_h1dv", 128'(obs_rsp[1].d_valid), 128'(1'b1));
    rd = mk_rsp(1'b0, 32'h0, 1'b1, 8'h00);
    step("s3_h0");
    check_eq("s3_h0_addr", 128'(obs_dev.a_address), 128'(32'h3000_0000));
    rq[0] = idle_h(1'b1);
    rd = mk_rsp(1'b1, 32'h1111_2222, 1'b1, 8'h01);
    step("s3_h0rsp");

    // response backpressure from the owner
    rq[0] = mk_get(32'h4000_0000, 8'h41, 1'b0);
    rd = mk_rsp(1'b0, 32'h0, 1'b1, 8'h00);
    step("s4_req");
    rq[0] = idle_h(1'b0);
    rq[1] = mk_get(32'h5000_0000, 8'h51, 1'b1);
    rd = mk_rsp(1'b1, 32'h1234_5678, 1'b1, 8'h41);
    for (int i = 0; i < 3; i++) begin
      step("s4_bp");
      check_eq("s4_dev_dr", 128'(obs_dev.d_ready), 128'(1'b0));
      check_eq("s4_ar", 128'({obs_rsp[0].a_ready, obs_rsp[1].a_ready}), 128'(2'b00));
    end
    rq[0] = idle_h(1'b1);
    step("s4_dfire");
    check_eq("s4_dev_dr1", 128'(obs_dev.d_ready), 128'(1'b1));
    rd = mk_rsp(1'b0, 32'h0, 1'b1, 8'h00);
    step("s4_next");
    check_eq("s4_next_addr", 128'(obs_dev.a_address), 128'(32'h5000_0000));
    check_eq("s4_next_ar", 128'(obs_rsp[1].a_ready), 128'(1'b1));
    rq[1] = idle_h(1'b1);
    rd = mk_rsp(1'b1, 32'h5555_AAAA, 1'b1, 8'h51);
    step("s4_rsp");

    // spurious device response while idle
    rq[0] = idle_h(1'b1);
    rq[1] = idle_h(1'b1);
    rd = mk_rsp(1'b1, 32'hDEAD_BEEF, 1'b1, 8'h77);
    step("s5_spur");
    check_eq("s5_dv", 128'({obs_rsp[0].d_valid, obs_rsp[1].d_valid}), 128'(2'b00));
    rq[0] = mk_get(32'h0000_0100, 8'h02, 1'b1);
    rd = mk_rsp(1'b0, 32'h0, 1'b1, 8'h00);
    step("s5_req");
    check_eq("s5_fire", 128'(obs_rsp[0].a_ready), 128'(1'b1));
    rq[0] = idle_h(1'b1);
    rd = mk_rsp(1'b1, 32'h0000_0BBB, 1'b1, 8'h02);
    step("s5_rsp");

    // reset while a transaction is outstanding
    rq[1] = mk_get(32'h6000_0000, 8'h61, 1'b1);
    rd = mk_rsp(1'b0, 32'h0, 1'b1, 8'h00);
    step("s6_req");
    rq[1] = idle_h(1'b1);
    rq[0] = mk_get(32'h7000_0000, 8'h07, 1'b1);
    rd = mk_rsp(1'b0, 32'h0, 1'b0, 8'h00);
    step("s6_busy");
    do_reset("s6_rst");
    check_eq("s6_rst_addr", 128'(obs_dev.a_address), 128'(32'h7000_0000));
    rq[0] = idle_h(1'b1);
    rq[1] = mk_get(32'h6000_0100, 8'h62, 1'b1);
    rd = mk_rsp(1'b0, 32'h0, 1'b1, 8'h00);
    step("s6_fresh");
    check_eq("s6_fresh_addr", 128'(obs_dev.a_address), 128'(32'h6000_0100));
    check_eq("s6_fresh_ar", 128'(obs_rsp[1].a_ready), 128'(1'b1));
    rq[1] = idle_h(1'b1);
    rd = mk_rsp(1'b1, 32'h6666_0000, 1'b1, 8'h62);
    step("s6_rsp");

    // both hosts requesting continuously: grants alternate from PRIO_INIT
    do_reset("s2_reset");
    gnt_log.delete();
    addr_log.delete();
    cnt[0] = 0;
    cnt[1] = 0;
    for (int c = 0; c < 40 && gnt_log.size() < 4; c++) begin
      for (int h = 0; h < 2; h++)
        rq[h] = mk_get(32'hA000_0000 + 32'(h * 256) + 32'(cnt[h] * 4), 8'(8'hB0 + h), 1'b1);
      rd = mk_rsp(m_busy, 32'hD000_0000 + 32'(c), 1'b1, 8'h00);
      step("s2_alt");
      if (m_afire) cnt[m_gnt]++;
    end
    check_eq("s2_count", 128'(gnt_log.size()), 128'(4));
    for (int i = 0; i < 4 && i < gnt_log.size(); i++) begin
      check_eq("s2_gnt", 128'(gnt_log[i]), 128'((i + PRIO) % 2));
      check_eq("s2_addr", 128'(addr_log[i]), 128'(32'hA000_0000 + 32'((i % 2) * 256) + 32'((i / 2) * 4)));
    end

    // random traffic against the model
    do_reset("rnd_reset");
    for (int c = 0; c < 400; c++) begin
      for (int h = 0; h < 2; h++) begin
        if ($urandom_range(0, 1) == 1)
          rq[h] = mk_get($urandom, 8'($urandom), 1'($urandom_range(0, 3) != 0));
        else
          rq[h] = idle_h(1'($urandom_range(0, 1)));
      end
      rd = mk_rsp(1'($urandom_range(0, 2) != 0), $urandom, 1'($urandom_range(0, 2) != 0), 8'($urandom));
      rd.d_error = 1'($urandom_range(0, 1));
      step("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
